// File: rtl/mem_op_sequencer.sv
// Memory-operation sequencer: validates a MOV request, steers byte lanes
// big-endian, runs a bounded req/ack cycle and reports completion or a trap.
module mem_op_sequencer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WAIT_MIN = 1,
  parameter int TIMEOUT  = 31
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  MOV,
  input  logic                  RW,
  input  logic [1:0]            op_type,
  input  logic                  SE,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [DATA_W-1:0]     WData,
  output logic [DATA_W-1:0]     RData,
  output logic                  MOC,
  output logic                  Fault,
  output logic [1:0]            FaultCode,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_MIN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic               dropped, dropped_next;
  logic [1:0]         code_next;
  logic               accept, ack_ok;
  logic               illegal_type, misaligned;
  logic [OFF_W-1:0]   off_q;
  logic [1:0]         size_q;
  logic               se_q, rw_q;

  function automatic int lane_count(input logic [1:0] size);
    int n;
    n = 1 << size;
    if (n > LANES) n = LANES;
    return n;
  endfunction

  // Lane 0 is the most significant byte, so it maps to the top enable bit.
  function automatic logic [LANES-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                 input logic [1:0] size);
    logic [LANES-1:0] m;
    int nb;
    nb = lane_count(size);
    m  = '0;
    for (int i = 0; i < LANES; i++)
      m[LANES-1-i] = (i >= int'(off)) && (i < int'(off) + nb);
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0] size);
    logic [DATA_W-1:0] r;
    int nb;
    nb = lane_count(size);
    r  = '0;
    for (int j = 0; j < LANES; j++)
      r[8*j +: 8] = d[8*(j % nb) +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] rd,
                                                input logic [OFF_W-1:0] off,
                                                input logic [1:0] size,
                                                input logic se);
    logic [DATA_W-1:0] s, r;
    logic fill;
    int nb, sh, top;
    nb  = lane_count(size);
    sh  = LANES - int'(off) - nb;
    if (sh < 0) sh = 0;
    top = 8 * nb - 1;
    s   = rd >> (8 * sh);
    fill = se & s[top];
    r   = '0;
    for (int b = 0; b < DATA_W; b++)
      r[b] = (b > top) ? fill : s[b];
    return r;
  endfunction

  always_comb begin
    illegal_type = (op_type == 2'b11) && (DATA_W == 32);
    case (op_type)
      2'b01:   misaligned = Addr[0];
      2'b10:   misaligned = |Addr[1:0];
      2'b11:   misaligned = |Addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // A request abandoned mid-cycle still finishes on the bus but returns
  // silently to IDLE instead of raising MOC or Fault.
  always_comb begin
    state_next   = state;
    count_next   = count;
    dropped_next = dropped;
    code_next    = FaultCode;
    accept       = 1'b0;
    ack_ok       = 1'b0;
    case (state)
      IDLE: begin
        if (MOV) begin
          count_next   = '0;
          dropped_next = 1'b0;
          if (illegal_type) begin
            state_next = FAULT;
            code_next  = 2'b10;
          end else if (misaligned) begin
            state_next = FAULT;
            code_next  = 2'b01;
          end else begin
            state_next = REQ;
            accept     = 1'b1;
          end
        end
      end
      REQ: begin
        if (!MOV) dropped_next = 1'b1;
        if (mem_ack && count >= WAIT_CNT) begin
          ack_ok     = 1'b1;
          state_next = (dropped || !MOV) ? IDLE : DONE;
        end else if (count == LAST_CNT) begin
          if (dropped || !MOV) begin
            state_next = IDLE;
          end else begin
            state_next = FAULT;
            code_next  = 2'b11;
          end
        end else begin
          count_next = count + 1'b1;
        end
      end
      DONE: begin
        if (!MOV) state_next = IDLE;
      end
      FAULT: begin
        if (!MOV) begin
          state_next = IDLE;
          code_next  = 2'b00;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state     <= IDLE;
      count     <= '0;
      dropped   <= 1'b0;
      FaultCode <= 2'b00;
    end else begin
      state     <= state_next;
      count     <= count_next;
      dropped   <= dropped_next;
      FaultCode <= code_next;
    end
  end

  // Bus outputs are loaded once on acceptance so they stay frozen for the
  // whole REQ stay, whatever the CPU does to its inputs meanwhile.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      RData     <= '0;
      off_q     <= '0;
      size_q    <= 2'b00;
      se_q      <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      if (accept) begin
        mem_req   <= 1'b1;
        mem_we    <= ~RW;
        mem_addr  <= {Addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_be    <= lane_mask(Addr[OFF_W-1:0], op_type);
        mem_wdata <= replicate(WData, op_type);
        off_q     <= Addr[OFF_W-1:0];
        size_q    <= op_type;
        se_q      <= SE;
        rw_q      <= RW;
      end else if (state == REQ && state_next != REQ) begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_be    <= '0;
        mem_wdata <= '0;
      end
      if (ack_ok && rw_q)
        RData <= extract(mem_rdata, off_q, size_q, se_q);
    end
  end

  assign MOC   = (state == DONE);
  assign Fault = (state == FAULT);

endmodule

// File: tb/tb_mem_op_sequencer.sv
// Bench for mem_op_sequencer: a 32-bit and a 64-bit instance share stimulus
// and are checked against a lane/latency model derived from the access rules.
module tb_mem_op_sequencer;

  localparam int WAIT_MIN = 1;
  localparam int TIMEOUT  = 31;

  logic        Clk = 1'b0;
  logic        Clr, mov_a, mov_b, RW, SE, mem_ack;
  logic [1:0]  op_type;
  logic [31:0] Addr;
  logic [63:0] WData, mem_rdata;

  logic [31:0] rdata_a, maddr_a, wdata_a;
  logic        moc_a, fault_a, req_a, we_a;
  logic [1:0]  code_a;
  logic [3:0]  be_a;
  logic [63:0] rdata_b, wdata_b;
  logic [31:0] maddr_b;
  logic        moc_b, fault_b, req_b, we_b;
  logic [1:0]  code_b;
  logic [7:0]  be_b;

  int          n_checks, n_fail;
  logic [63:0] model_rd32, model_rd64;

  mem_op_sequencer #(.DATA_W(32), .ADDR_W(32), .WAIT_MIN(WAIT_MIN), .TIMEOUT(TIMEOUT)) dut32 (
    .Clk(Clk), .Clr(Clr), .MOV(mov_a), .RW(RW), .op_type(op_type), .SE(SE),
    .Addr(Addr), .WData(WData[31:0]), .RData(rdata_a), .MOC(moc_a), .Fault(fault_a),
    .FaultCode(code_a), .mem_req(req_a), .mem_we(we_a), .mem_addr(maddr_a),
    .mem_be(be_a), .mem_wdata(wdata_a), .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack));

  mem_op_sequencer #(.DATA_W(64), .ADDR_W(32), .WAIT_MIN(WAIT_MIN), .TIMEOUT(TIMEOUT)) dut64 (
    .Clk(Clk), .Clr(Clr), .MOV(mov_b), .RW(RW), .op_type(op_type), .SE(SE),
    .Addr(Addr), .WData(WData), .RData(rdata_b), .MOC(moc_b), .Fault(fault_b),
    .FaultCode(code_b), .mem_req(req_b), .mem_we(we_b), .mem_addr(maddr_b),
    .mem_be(be_b), .mem_wdata(wdata_b), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: accessed bytes are [off, off+size) counted from the MSB.
  function automatic logic [7:0] m_be(input int lanes, input int off, input logic [1:0] t);
    int nb;
    nb = 1 << t;
    return 8'(((1 << nb) - 1) << (lanes - off - nb));
  endfunction

  function automatic logic [63:0] m_wdata(input int lanes, input logic [63:0] wd, input logic [1:0] t);
    int nb;
    logic [63:0] unit, rep;
    nb   = 1 << t;
    unit = (nb == 8) ? wd : (wd & ((64'd1 << (8 * nb)) - 64'd1));
    rep  = '0;
    for (int k = 0; k < lanes / nb; k++) rep = rep | (unit << (8 * nb * k));
    return rep;
  endfunction

  function automatic logic [63:0] m_rdata(input int lanes, input logic [63:0] rd, input int off,
                                          input logic [1:0] t, input bit se);
    int nb;
    logic [63:0] v, mask;
    nb = 1 << t;
    if (lanes == 4) rd = rd & 64'hFFFF_FFFF;
    v    = rd >> (8 * (lanes - off - nb));
    mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (se && v[8*nb-1]) v = v | ~mask;
    if (lanes == 4) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic observe(input bit wide, output logic req, output logic we, output logic moc,
                         output logic fault, output logic [1:0] code, output logic [31:0] addr,
                         output logic [7:0] be, output logic [63:0] wdata, output logic [63:0] rdata);
    if (wide) begin
      req = req_b; we = we_b; moc = moc_b; fault = fault_b; code = code_b;
      addr = maddr_b; be = be_b; wdata = wdata_b; rdata = rdata_b;
    end else begin
      req = req_a; we = we_a; moc = moc_a; fault = fault_a; code = code_a;
      addr = maddr_a; be = {4'b0, be_a}; wdata = {32'b0, wdata_a}; rdata = {32'b0, rdata_a};
    end
  endtask

  task automatic run_op(input bit wide, input bit rw, input logic [1:0] t, input bit se,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int d, input bit gap, input string tag);
    int lanes, off, lat, want_lat;
    bit done, unstable;
    logic o_req, o_we, o_moc, o_fault;
    logic [1:0] o_code;
    logic [31:0] o_addr, e_addr, s_addr;
    logic [7:0] o_be, e_be, s_be;
    logic [63:0] o_wdata, o_rdata, e_wd, s_wdata, e_rd;
    lanes = wide ? 8 : 4;
    off   = int'(a % lanes);
    RW = rw; op_type = t; SE = se; Addr = a; WData = wd; mem_rdata = rd; mem_ack = 1'b0;
    if (wide) mov_b = 1'b1; else mov_a = 1'b1;
    tick();
    observe(wide, o_req, o_we, o_moc, o_fault, o_code, o_addr, o_be, o_wdata, o_rdata);
    e_addr = a & ~32'(lanes - 1);
    e_be   = m_be(lanes, off, t);
    e_wd   = m_wdata(lanes, wd, t);
    n_checks++; if (o_req !== 1'b1) begin n_fail++; $display("[TB] FAIL %s req: got %b want 1", tag, o_req); end
    n_checks++; if (o_we !== ~rw) begin n_fail++; $display("[TB] FAIL %s we: got %b want %b", tag, o_we, ~rw); end
    n_checks++; if (o_addr !== e_addr) begin n_fail++; $display("[TB] FAIL %s addr: got %h want %h", tag, o_addr, e_addr); end
    n_checks++; if (o_be !== e_be) begin n_fail++; $display("[TB] FAIL %s be: got %b want %b", tag, o_be, e_be); end
    if (!rw) begin
      n_checks++; if (o_wdata !== e_wd) begin n_fail++; $display("[TB] FAIL %s wdata: got %h want %h", tag, o_wdata, e_wd); end
    end
    s_addr = o_addr; s_be = o_be; s_wdata = o_wdata;
    Addr = $urandom; WData = {$urandom, $urandom}; SE = ~se;
    done = 0; unstable = 0; lat = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_ack = (c >= d);
      tick();
      observe(wide, o_req, o_we, o_moc, o_fault, o_code, o_addr, o_be, o_wdata, o_rdata);
      if (o_moc) begin
        done = 1; lat = c + 2;
      end else if ({o_req, o_we, o_addr, o_be, o_wdata} !== {1'b1, ~rw, s_addr, s_be, s_wdata}) begin
        unstable = 1;
      end
    end
    want_lat = 2 + ((WAIT_MIN > d) ? WAIT_MIN : d);
    n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL %s moc: never rose within 40 cycles", tag); end
    n_checks++; if (lat != want_lat) begin n_fail++; $display("[TB] FAIL %s latency: got %0d edges want %0d", tag, lat, want_lat); end
    n_checks++; if (unstable) begin n_fail++; $display("[TB] FAIL %s bus_stable: outputs changed during REQ, got 1 want 0", tag); end
    n_checks++; if ({o_req, o_fault} !== 2'b00) begin n_fail++; $display("[TB] FAIL %s done_req_fault: got %b want 00", tag, {o_req, o_fault}); end
    if (rw) begin
      if (wide) model_rd64 = m_rdata(8, rd, off, t, se);
      else      model_rd32 = m_rdata(4, rd, off, t, se);
    end
    e_rd = wide ? model_rd64 : model_rd32;
    n_checks++; if (o_rdata !== e_rd) begin n_fail++; $display("[TB] FAIL %s rdata: got %h want %h", tag, o_rdata, e_rd); end
    mem_ack = 1'b0;
    tick();
    observe(wide, o_req, o_we, o_moc, o_fault, o_code, o_addr, o_be, o_wdata, o_rdata);
    n_checks++; if (o_moc !== 1'b1) begin n_fail++; $display("[TB] FAIL %s moc_hold: got %b want 1", tag, o_moc); end
    mov_a = 1'b0; mov_b = 1'b0;
    tick();
    observe(wide, o_req, o_we, o_moc, o_fault, o_code, o_addr, o_be, o_wdata, o_rdata);
    n_checks++; if (o_moc !== 1'b0) begin n_fail++; $display("[TB] FAIL %s moc_drop: got %b want 0", tag, o_moc); end
    if (gap) tick();
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({rdata_a, moc_a, fault_a, code_a, req_a, we_a, maddr_a, be_a, wdata_a} !== '0) begin
      n_fail++; $display("[TB] FAIL reset32: outputs got %h want 0", {rdata_a, moc_a, fault_a, code_a, req_a, we_a, maddr_a, be_a, wdata_a});
    end
    n_checks++;
    if ({rdata_b, moc_b, fault_b, code_b, req_b, we_b, maddr_b, be_b, wdata_b} !== '0) begin
      n_fail++; $display("[TB] FAIL reset64: outputs got %h want 0", {rdata_b, moc_b, fault_b, code_b, req_b, we_b, maddr_b, be_b, wdata_b});
    end
    Clr = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    run_op(0, 1, 2'b10, 0, 32'h104, 64'h0, 64'hDEADBEEF, 2, 1, "word_load");
  endtask

  task automatic test_byte_load();
    run_op(0, 1, 2'b00, 1, 32'h103, 64'h0, 64'h000000F0, 1, 1, "byte_load_se");
    run_op(0, 1, 2'b00, 0, 32'h103, 64'h0, 64'h000000F0, 1, 1, "byte_load_ze");
    run_op(0, 1, 2'b01, 1, 32'h100, 64'h0, 64'h8001_7F00, 3, 1, "half_load_se");
  endtask

  task automatic test_half_store();
    run_op(0, 0, 2'b01, 0, 32'h202, 64'h1234ABCD, 64'h0, 1, 1, "half_store");
    run_op(0, 0, 2'b00, 0, 32'h201, 64'h0000005A, 64'h0, 0, 1, "byte_store");
  endtask

  task automatic test_best_case();
    run_op(0, 1, 2'b10, 0, 32'h10, 64'h0, 64'hCAFEF00D, 0, 1, "ack_early");
    run_op(0, 1, 2'b10, 0, 32'h14, 64'h0, 64'h0BADF00D, 1, 1, "ack_first");
  endtask

  task automatic test_faults();
    logic [1:0]  tt[4] = '{2'b01, 2'b11, 2'b11, 2'b10};
    logic [31:0] aa[4] = '{32'h201, 32'h100, 32'h101, 32'h102};
    logic [1:0]  cc[4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    bit bad;
    for (int i = 0; i < 4; i++) begin
      RW = 1'b1; op_type = tt[i]; Addr = aa[i]; mov_a = 1'b1;
      tick();
      n_checks++; if ({fault_a, code_a, req_a, moc_a} !== {1'b1, cc[i], 2'b00}) begin
        n_fail++; $display("[TB] FAIL fault%0d entry: fault/code/req/moc got %b want %b", i, {fault_a, code_a, req_a, moc_a}, {1'b1, cc[i], 2'b00});
      end
      bad = 0;
      repeat (3) begin
        tick();
        if ({fault_a, code_a, req_a} !== {1'b1, cc[i], 1'b0}) bad = 1;
      end
      n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL fault%0d hold: got 1 want 0", i); end
      mov_a = 1'b0;
      tick();
      n_checks++; if ({fault_a, code_a} !== 3'b000) begin
        n_fail++; $display("[TB] FAIL fault%0d clear: got %b want 000", i, {fault_a, code_a});
      end
      tick();
    end
  endtask

  task automatic test_timeout(input bit ack_end);
    int hit;
    logic [63:0] rd;
    rd = {32'h0, $urandom};
    RW = 1'b1; op_type = 2'b10; Addr = 32'h40; SE = 1'b0; mem_rdata = rd; mem_ack = 1'b0; mov_a = 1'b1;
    tick();
    hit = 0;
    for (int i = 1; i <= 40; i++) begin
      mem_ack = ack_end && (i == TIMEOUT);
      tick();
      if (moc_a || fault_a) begin hit = i; break; end
    end
    n_checks++; if (hit != TIMEOUT) begin n_fail++; $display("[TB] FAIL timeout%0d cycles: got %0d want %0d", ack_end, hit, TIMEOUT); end
    if (ack_end) begin
      model_rd32 = m_rdata(4, rd, 0, 2'b10, 0);
      n_checks++; if ({moc_a, fault_a} !== 2'b10) begin n_fail++; $display("[TB] FAIL timeout_ack moc/fault: got %b want 10", {moc_a, fault_a}); end
      n_checks++; if (rdata_a !== model_rd32[31:0]) begin n_fail++; $display("[TB] FAIL timeout_ack rdata: got %h want %h", rdata_a, model_rd32[31:0]); end
    end else begin
      n_checks++; if ({moc_a, fault_a, code_a, req_a} !== 5'b01110) begin
        n_fail++; $display("[TB] FAIL timeout moc/fault/code/req: got %b want 01110", {moc_a, fault_a, code_a, req_a});
      end
    end
    mem_ack = 1'b0; mov_a = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_req();
    RW = 1'b1; op_type = 2'b10; Addr = 32'h80; mem_rdata = 64'h55AA55AA; mem_ack = 1'b0; mov_a = 1'b1;
    repeat (3) tick();
    Clr = 1'b1; mem_ack = 1'b1; mov_a = 1'b0;
    tick();
    model_rd32 = '0; model_rd64 = '0;
    n_checks++;
    if ({rdata_a, moc_a, fault_a, code_a, req_a, we_a, maddr_a, be_a, wdata_a} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_mid_req: outputs got %h want 0", {rdata_a, moc_a, fault_a, code_a, req_a, we_a, maddr_a, be_a, wdata_a});
    end
    Clr = 1'b0; mem_ack = 1'b0;
    tick();
    run_op(0, 1, 2'b10, 0, 32'h84, 64'h0, 64'h13579BDF, 2, 1, "after_reset");
  endtask

  task automatic test_mov_drop();
    bit bad;
    RW = 1'b0; op_type = 2'b10; Addr = 32'h300; WData = 64'h77; mem_ack = 1'b0; mov_a = 1'b1;
    tick();
    mov_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      mem_ack = (i >= 1);
      tick();
      if (moc_a || fault_a) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("[TB] FAIL mov_drop moc_or_fault: got 1 want 0"); end
    n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("[TB] FAIL mov_drop req: got %b want 0", req_a); end
    mem_ack = 1'b0;
    tick();
    run_op(0, 0, 2'b10, 0, 32'h304, 64'h89ABCDEF, 64'h0, 1, 1, "after_drop");
  endtask

  task automatic test_wide();
    run_op(1, 1, 2'b11, 0, 32'h8, 64'h0, 64'h0123456789ABCDEF, 1, 1, "dword_load");
    run_op(1, 0, 2'b10, 0, 32'h104, 64'h1122334455667788, 64'h0, 2, 1, "wide_word_store");
    run_op(1, 1, 2'b00, 1, 32'h5, 64'h0, 64'h0000_0000_0080_0000, 0, 1, "wide_byte_se");
  endtask

  task automatic test_back_to_back();
    run_op(0, 1, 2'b00, 0, 32'h50, 64'h0, 64'h11223344, 1, 0, "b2b_first");
    run_op(0, 0, 2'b01, 0, 32'h52, 64'hBEEF, 64'h0, 0, 0, "b2b_second");
    run_op(0, 1, 2'b10, 1, 32'h58, 64'h0, 64'h89ABCDEF, 2, 1, "b2b_third");
  endtask

  task automatic test_random();
    bit wide, rw, se, gap;
    logic [1:0] t;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      wide = 1'($urandom_range(0, 1));
      t    = 2'(wide ? $urandom_range(0, 3) : $urandom_range(0, 2));
      a    = ($urandom & 32'h0000_FFFF) & ~((32'd1 << t) - 32'd1);
      rw   = 1'($urandom_range(0, 1));
      se   = 1'($urandom_range(0, 1));
      gap  = 1'($urandom_range(0, 1));
      run_op(wide, rw, t, se, a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 4), gap, "random");
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    model_rd32 = '0; model_rd64 = '0;
    Clr = 1'b1; mov_a = 1'b0; mov_b = 1'b0; RW = 1'b0; op_type = 2'b00; SE = 1'b0;
    Addr = '0; WData = '0; mem_rdata = '0; mem_ack = 1'b0;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_best_case();
    test_faults();
    test_timeout(0);
    test_timeout(1);
    test_reset_mid_req();
    test_mov_drop();
    test_wide();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
